ps2_jpd_decoder: RTL and testbench

Converts a PS/2 keyboard stream into the two 10-bit active-high joypad vectors consumed by the joypad controller, so a keyboard can stand in for both players' gamepads. It samples the asynchronous PS/2 clock/data lines, deframes scan-code set 2 bytes, tracks make/break and extended prefixes, and holds one pressed/released bit per mapped key. It sits directly upstream of the joypad controller, driving its 1P and 2P vector inputs.

---
 rtl/ps2_jpd_decoder_pkg.sv | 79 +++++++
 rtl/ps2_jpd_decoder_if.sv | 18 +
 rtl/ps2_jpd_decoder_rx.sv | 97 +++++++++
 rtl/ps2_jpd_decoder.sv | 66 ++++++
 tb/tb_ps2_jpd_decoder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_jpd_decoder_pkg.sv
// Shared constants for the PS/2 keyboard to joypad decoder:
// joypad bit positions, special scan codes and the key map.
package jpd_pkg;

  localparam int unsigned JPD_UP      = 9;
  localparam int unsigned JPD_DOWN    = 8;
  localparam int unsigned JPD_LEFT    = 7;
  localparam int unsigned JPD_RIGHT   = 6;
  localparam int unsigned JPD_B       = 5;
  localparam int unsigned JPD_A       = 4;
  localparam int unsigned JPD_TURBO_B = 3;
  localparam int unsigned JPD_TURBO_A = 2;
  localparam int unsigned JPD_SELECT  = 1;
  localparam int unsigned JPD_START   = 0;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_BAT = 8'hAA;
  localparam logic [7:0] SC_ERR = 8'hFF;

  // Key map entries are {ext, code}
  localparam logic [8:0] K1_UP      = 9'h01D;
  localparam logic [8:0] K1_DOWN    = 9'h01B;
  localparam logic [8:0] K1_LEFT    = 9'h01C;
  localparam logic [8:0] K1_RIGHT   = 9'h023;
  localparam logic [8:0] K1_B       = 9'h03B;
  localparam logic [8:0] K1_A       = 9'h042;
  localparam logic [8:0] K1_TURBO_B = 9'h03C;
  localparam logic [8:0] K1_TURBO_A = 9'h043;
  localparam logic [8:0] K1_SELECT  = 9'h034;
  localparam logic [8:0] K1_START   = 9'h033;

  localparam logic [8:0] K2_UP      = 9'h175;
  localparam logic [8:0] K2_DOWN    = 9'h172;
  localparam logic [8:0] K2_LEFT    = 9'h16B;
  localparam logic [8:0] K2_RIGHT   = 9'h174;
  localparam logic [8:0] K2_START   = 9'h15A;
  localparam logic [8:0] K2_B       = 9'h069;
  localparam logic [8:0] K2_A       = 9'h072;
  localparam logic [8:0] K2_TURBO_B = 9'h06B;
  localparam logic [8:0] K2_TURBO_A = 9'h073;
  localparam logic [8:0] K2_SELECT  = 9'h075;

  typedef struct packed {
    logic       hit;
    logic       p2;
    logic [3:0] idx;
  } key_hit_t;

  function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
    key_hit_t k;
    k = '{hit: 1'b1, p2: 1'b0, idx: 4'd0};
    case ({ext, code})
      K1_UP:      k.idx = 4'(JPD_UP);
      K1_DOWN:    k.idx = 4'(JPD_DOWN);
      K1_LEFT:    k.idx = 4'(JPD_LEFT);
      K1_RIGHT:   k.idx = 4'(JPD_RIGHT);
      K1_B:       k.idx = 4'(JPD_B);
      K1_A:       k.idx = 4'(JPD_A);
      K1_TURBO_B: k.idx = 4'(JPD_TURBO_B);
      K1_TURBO_A: k.idx = 4'(JPD_TURBO_A);
      K1_SELECT:  k.idx = 4'(JPD_SELECT);
      K1_START:   k.idx = 4'(JPD_START);
      K2_UP:      begin k.p2 = 1'b1; k.idx = 4'(JPD_UP);      end
      K2_DOWN:    begin k.p2 = 1'b1; k.idx = 4'(JPD_DOWN);    end
      K2_LEFT:    begin k.p2 = 1'b1; k.idx = 4'(JPD_LEFT);    end
      K2_RIGHT:   begin k.p2 = 1'b1; k.idx = 4'(JPD_RIGHT);   end
      K2_START:   begin k.p2 = 1'b1; k.idx = 4'(JPD_START);   end
      K2_B:       begin k.p2 = 1'b1; k.idx = 4'(JPD_B);       end
      K2_A:       begin k.p2 = 1'b1; k.idx = 4'(JPD_A);       end
      K2_TURBO_B: begin k.p2 = 1'b1; k.idx = 4'(JPD_TURBO_B); end
      K2_TURBO_A: begin k.p2 = 1'b1; k.idx = 4'(JPD_TURBO_A); end
      K2_SELECT:  begin k.p2 = 1'b1; k.idx = 4'(JPD_SELECT);  end
      default:    k.hit = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ps2_jpd_decoder_if.sv
// PS/2 pins in, joypad vectors and frame error out.
interface ps2_jpd_decoder_if;
  logic       i_ps2_clk;
  logic       i_ps2_data;
  logic [9:0] o_jpd_1p;
  logic [9:0] o_jpd_2p;
  logic       o_frame_err;

  modport master (
    output i_ps2_clk, i_ps2_data,
    input  o_jpd_1p, o_jpd_2p, o_frame_err
  );

  modport slave (
    input  i_ps2_clk, i_ps2_data,
    output o_jpd_1p, o_jpd_2p, o_frame_err
  );
endinterface

// File: rtl/ps2_jpd_decoder_rx.sv
// PS/2 receiver: synchronizers, 11-bit frame FSM, inactivity timeout.
module ps2_rx #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_prev;
  logic          fall;
  logic          data_s;
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [CW-1:0] cnt;

  // Two-flop synchronizers; reset to the idle-high line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign data_s = data_sync[1];

  // Frame FSM and timeout; an edge in the timeout cycle takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      cnt        <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        cnt <= '0;
        case (state)
          S_IDLE: begin
            if (!data_s) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par   <= data_s;
            state <= S_STOP;
          end
          default: begin
            state <= S_IDLE;
            if (data_s && (^{shreg, par})) byte_valid <= 1'b1;
            else                           frame_err  <= 1'b1;
          end
        endcase
      end else begin
        if (cnt != '1) cnt <= cnt + 1'b1;
        if (state != S_IDLE && cnt == CW'(TIMEOUT_CYC - 1)) begin
          state     <= S_IDLE;
          frame_err <= 1'b1;
        end
      end
    end
  end

  assign data_byte = shreg;

endmodule

// File: rtl/ps2_jpd_decoder.sv
// PS/2 keyboard to dual joypad vector decoder (top level).
module ps2_jpd_decoder
  import jpd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  ps2_jpd_decoder_if.slave   ps2
);

  logic [7:0] data_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       ext;
  logic       brk;
  logic [9:0] jpd_1p;
  logic [9:0] jpd_2p;
  key_hit_t   key;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk        (i_clk),
    .rst_n      (i_rstn),
    .ps2_clk    (ps2.i_ps2_clk),
    .ps2_data   (ps2.i_ps2_data),
    .data_byte  (data_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_err)
  );

  assign key = key_lookup(ext, data_byte);

  // Prefix tracking and key state update on each received byte
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ext    <= 1'b0;
      brk    <= 1'b0;
      jpd_1p <= '0;
      jpd_2p <= '0;
    end else if (rx_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (rx_valid) begin
      if (data_byte == SC_EXT) begin
        ext <= 1'b1;
      end else if (data_byte == SC_BRK) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (data_byte == SC_BAT || data_byte == SC_ERR) begin
          jpd_1p <= '0;
          jpd_2p <= '0;
        end else if (key.hit) begin
          if (key.p2) jpd_2p[key.idx] <= ~brk;
          else        jpd_1p[key.idx] <= ~brk;
        end
      end
    end
  end

  assign ps2.o_jpd_1p    = jpd_1p;
  assign ps2.o_jpd_2p    = jpd_2p;
  assign ps2.o_frame_err = rx_err;

endmodule

// File: tb/tb_ps2_jpd_decoder.sv
// Self-checking bench for ps2_jpd_decoder: directed scenarios then random byte stream.
module tb_ps2_jpd_decoder;

  localparam int unsigned TO   = 300;
  localparam int unsigned HALF = 6;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_bad;
  int   err_cycles;
  int   exp_err;

  logic [9:0] m1p;
  logic [9:0] m2p;
  logic       m_ext;
  logic       m_brk;

  typedef struct {
    logic       ext;
    logic [7:0] code;
    logic       p2;
    int         idx;
  } map_t;
  map_t keymap[20];

  ps2_jpd_decoder_if ifc ();

  ps2_jpd_decoder #(.TIMEOUT_CYC(TO)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .ps2    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ifc.o_frame_err === 1'b1) err_cycles++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_1p"}, {22'd0, ifc.o_jpd_1p}, {22'd0, m1p});
    check({tag, "_2p"}, {22'd0, ifc.o_jpd_2p}, {22'd0, m2p});
    check({tag, "_err"}, err_cycles, exp_err);
  endtask

  // Behavioural effect of one received byte (good) or one rejected frame
  task automatic model_byte(input logic [7:0] b, input logic good);
    if (!good) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (b == 8'hAA || b == 8'hFF) begin
        m1p = '0;
        m2p = '0;
      end else begin
        foreach (keymap[i]) begin
          if (keymap[i].ext == m_ext && keymap[i].code == b) begin
            if (keymap[i].p2) m2p[keymap[i].idx] = ~m_brk;
            else              m1p[keymap[i].idx] = ~m_brk;
          end
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ifc.i_ps2_data = bits[i];
      wait_cyc(HALF);
      ifc.i_ps2_clk = 1'b0;
      wait_cyc(HALF);
      ifc.i_ps2_clk = 1'b1;
    end
    ifc.i_ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bits({1'b1, par, b, 1'b0}, 11);
    wait_cyc(8);
    model_byte(b, ~bad_par);
  endtask

  task automatic send_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
    send_frame(a, 1'b0);
    if (n > 1) send_frame(b, 1'b0);
    if (n > 2) send_frame(c, 1'b0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    wait_cyc(4);
    m1p = '0; m2p = '0; m_ext = 1'b0; m_brk = 1'b0;
    rstn = 1'b1;
    wait_cyc(4);
  endtask

  logic [7:0] pool[17];

  initial begin
    keymap[0]  = '{1'b0, 8'h1D, 1'b0, 9};
    keymap[1]  = '{1'b0, 8'h1B, 1'b0, 8};
    keymap[2]  = '{1'b0, 8'h1C, 1'b0, 7};
    keymap[3]  = '{1'b0, 8'h23, 1'b0, 6};
    keymap[4]  = '{1'b0, 8'h3B, 1'b0, 5};
    keymap[5]  = '{1'b0, 8'h42, 1'b0, 4};
    keymap[6]  = '{1'b0, 8'h3C, 1'b0, 3};
    keymap[7]  = '{1'b0, 8'h43, 1'b0, 2};
    keymap[8]  = '{1'b0, 8'h34, 1'b0, 1};
    keymap[9]  = '{1'b0, 8'h33, 1'b0, 0};
    keymap[10] = '{1'b1, 8'h75, 1'b1, 9};
    keymap[11] = '{1'b1, 8'h72, 1'b1, 8};
    keymap[12] = '{1'b1, 8'h6B, 1'b1, 7};
    keymap[13] = '{1'b1, 8'h74, 1'b1, 6};
    keymap[14] = '{1'b1, 8'h5A, 1'b1, 0};
    keymap[15] = '{1'b0, 8'h69, 1'b1, 5};
    keymap[16] = '{1'b0, 8'h72, 1'b1, 4};
    keymap[17] = '{1'b0, 8'h6B, 1'b1, 3};
    keymap[18] = '{1'b0, 8'h73, 1'b1, 2};
    keymap[19] = '{1'b0, 8'h75, 1'b1, 1};
    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h3B, 8'h42, 8'h3C, 8'h43, 8'h34,
             8'h33, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h69, 8'h73};

    n_cmp = 0; n_bad = 0; err_cycles = 0; exp_err = 0;
    ifc.i_ps2_clk  = 1'b1;
    ifc.i_ps2_data = 1'b1;
    rstn = 1'b1;
    wait_cyc(1);
    do_reset();
    check_all("reset");
    check("reset_ferr", {31'd0, ifc.o_frame_err}, 32'd0);

    // Make then break of W
    send_frame(8'h1D, 1'b0);
    check("w_make", {22'd0, ifc.o_jpd_1p}, 32'h200);
    send_seq(8'hF0, 8'h1D, 8'h00, 2);
    check("w_break", {22'd0, ifc.o_jpd_1p}, 32'h000);
    check_all("w");

    // Extended vs plain 72
    send_seq(8'hE0, 8'h72, 8'h72, 3);
    check("down_a", {22'd0, ifc.o_jpd_2p}, 32'h110);
    send_seq(8'hE0, 8'hF0, 8'h72, 3);
    check("down_rel", {22'd0, ifc.o_jpd_2p}, 32'h010);
    check_all("ext");

    // Bad parity then recovery
    send_frame(8'h42, 1'b1);
    check("badpar_1p", {22'd0, ifc.o_jpd_1p}, 32'h000);
    check("badpar_err", err_cycles, 32'd1);
    send_frame(8'h1D, 1'b0);
    check("recover", {22'd0, ifc.o_jpd_1p}, 32'h200);
    check_all("par");

    // Timeout after E0 prefix clears ext
    send_seq(8'hF0, 8'h72, 8'h00, 2);
    send_frame(8'hE0, 1'b0);
    send_bits(11'h000, 4);
    wait_cyc(TO + 20);
    model_byte(8'h00, 1'b0);
    check("timeout_err", err_cycles, exp_err);
    send_frame(8'h72, 1'b0);
    check("timeout_a", {22'd0, ifc.o_jpd_2p}, 32'h010);
    check_all("to");

    // BAT clears all held keys
    send_seq(8'h1C, 8'h42, 8'h69, 3);
    send_frame(8'hAA, 1'b0);
    check("bat_1p", {22'd0, ifc.o_jpd_1p}, 32'h000);
    check("bat_2p", {22'd0, ifc.o_jpd_2p}, 32'h000);

    // Reset mid-frame with a break prefix pending
    send_frame(8'h23, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_bits(11'h000, 5);
    do_reset();
    check_all("midrst");
    send_frame(8'h1D, 1'b0);
    check("post_rst", {22'd0, ifc.o_jpd_1p}, 32'h200);

    // Unmapped key make/break
    send_seq(8'h29, 8'hF0, 8'h29, 3);
    check_all("unmapped");

    // Random byte stream against the model
    for (int n = 0; n < 100; n++) begin
      int unsigned r;
      logic [7:0]  b;
      logic        bad;
      r = $urandom_range(0, 99);
      if (r < 15)      b = 8'hE0;
      else if (r < 35) b = 8'hF0;
      else if (r < 38) b = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFF;
      else if (r < 45) b = 8'h29;
      else             b = pool[$urandom_range(0, 16)];
      bad = ($urandom_range(0, 11) == 0);
      send_frame(b, bad);
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
